// File: rtl/cpu_pkg.sv
// Shared encodings for the ALU front end: operation codes and arbiter FSM states.
package cpu_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StIssue   = 2'b01,
        StRespond = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for the two-port ALU arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 8
);
    import cpu_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req0_op;
    logic [OP_W-1:0]   req1_op;
    logic              req0_ready;
    logic              req1_ready;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_carry;
    logic              busy;
    logic              owner;

    // Arbiter side.
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        input  alu_result, alu_zero, alu_carry,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_carry, busy, owner
    );

    // Requesters plus external ALU side.
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        output alu_result, alu_zero, alu_carry,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_carry, busy, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin select: pointer breaks ties, a lone requester always wins.
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        if (&i_valid) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; one operation per
// IDLE -> ISSUE -> RESPOND pass.
module alu_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    state_e            r_state;
    logic              r_ptr;
    logic              r_owner;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_carry;

    logic [1:0] w_valid;
    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic       w_xfer;
    logic       w_live;

    assign w_valid = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .i_valid (w_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Reset masks every handshake/status output, even mid-operation.
    assign w_live  = !reset;
    assign w_ready = (w_live && r_state == StIdle) ? w_grant : 2'b00;
    assign w_xfer  = |w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_carry  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_xfer) begin
                        r_state  <= StIssue;
                        r_owner  <= w_grant[1];
                        r_ptr    <= w_grant[0];
                        r_alu_a  <= w_grant[1] ? bus.req1_a  : bus.req0_a;
                        r_alu_b  <= w_grant[1] ? bus.req1_b  : bus.req0_b;
                        r_alu_op <= w_grant[1] ? bus.req1_op : bus.req0_op;
                    end
                end
                StIssue: begin
                    r_state      <= StRespond;
                    r_rsp_result <= bus.alu_result;
                    r_rsp_zero   <= bus.alu_zero;
                    r_rsp_carry  <= bus.alu_carry;
                end
                StRespond: r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp0_valid = w_live && (r_state == StRespond) && !r_owner;
    assign bus.rsp1_valid = w_live && (r_state == StRespond) && r_owner;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.busy       = w_live && (r_state != StIdle);
    assign bus.owner      = r_owner;

endmodule
